serial_adder: RTL and testbench

//   Parametrised bit-serial adder/subtractor built around a single full-adder cell and a carry flop.

---
 rtl/serial_adder.sv | 173 +++++++++++++++++
 tb/tb_serial_adder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flop process
// the operands LSB-first, one bit per clock, under a start/busy/done handshake.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             SUB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] SUM,
  output logic             CARRY,
  output logic             OVERFLOW
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             accept_s;
  logic             last_s;
  logic             fa_sum_s;
  logic             fa_carry_s;
  logic [WIDTH:0]   sum_ext_s;
  logic [WIDTH-1:0] sum_shift_s;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Handshake qualifiers and the single full-adder cell.
  always_comb begin
    accept_s    = start && ((state_q == IDLE) || (state_q == DONE));
    last_s      = (state_q == RUN) && (cnt_q == CW'(WIDTH - 1));
    fa_sum_s    = opa_q[0] ^ opb_q[0] ^ c_q;
    fa_carry_s  = maj3(opa_q[0], opb_q[0], c_q);
    sum_ext_s   = {fa_sum_s, sum_sr_q};
    sum_shift_s = sum_ext_s[WIDTH:1];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
        else       state_d = IDLE;
      end
      RUN: begin
        if (last_s) state_d = DONE;
        else        state_d = RUN;
      end
      DONE: begin
        if (start) state_d = RUN;
        else       state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode, taken from the next state so busy/done come straight off flops.
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_d)
      IDLE:    begin busy_d = 1'b0; done_d = 1'b0; end
      RUN:     begin busy_d = 1'b1; done_d = 1'b0; end
      DONE:    begin busy_d = 1'b0; done_d = 1'b1; end
      default: begin busy_d = 1'b0; done_d = 1'b0; end
    endcase
  end

  // Operand shifters, carry, bit counter and result capture.
  always_comb begin
    opa_d    = opa_q;
    opb_d    = opb_q;
    c_d      = c_q;
    cnt_d    = cnt_q;
    sum_sr_d = sum_sr_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    if (accept_s) begin
      // Subtraction is A + ~B + 1, so the inversion and the forced carry happen at load.
      opa_d = A;
      opb_d = SUB ? ~B : B;
      c_d   = SUB ? 1'b1 : Cin;
      cnt_d = '0;
    end else if (state_q == RUN) begin
      opa_d    = opa_q >> 1;
      opb_d    = opb_q >> 1;
      c_d      = fa_carry_s;
      sum_sr_d = sum_shift_s;
      cnt_d    = cnt_q + CW'(1);
      if (last_s) begin
        // c_q here is the carry into the MSB.
        sum_d   = sum_shift_s;
        carry_d = fa_carry_s;
        ovf_d   = c_q ^ fa_carry_s;
      end else begin
        sum_d   = sum_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
      end
    end else begin
      opa_d = opa_q;
      opb_d = opb_q;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa_q    <= '0;
      opb_q    <= '0;
      sum_sr_q <= '0;
      cnt_q    <= '0;
      c_q      <= 1'b0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      sum_sr_q <= sum_sr_d;
      cnt_q    <= cnt_d;
      c_q      <= c_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign SUM      = sum_q;
  assign CARRY    = carry_q;
  assign OVERFLOW = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: WIDTH=8 instance checked every cycle against an
// arithmetic reference, plus directed cases and a WIDTH=1 truth-table sweep.
module tb_serial_adder;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] A, B;
  logic       Cin, SUB;
  logic       busy, done;
  logic [7:0] SUM;
  logic       CARRY, OVERFLOW;

  logic       start1;
  logic [0:0] a1, b1;
  logic       cin1, sub1;
  logic       busy1, done1;
  logic [0:0] sum1;
  logic       carry1, ovf1;

  int n_cmp = 0;
  int n_fail = 0;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .Cin(Cin), .SUB(SUB),
    .busy(busy), .done(done), .SUM(SUM), .CARRY(CARRY), .OVERFLOW(OVERFLOW)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .A(a1), .B(b1), .Cin(cin1), .SUB(sub1),
    .busy(busy1), .done(done1), .SUM(sum1), .CARRY(carry1), .OVERFLOW(ovf1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result: {overflow, carry, sum} from plain arithmetic.
  function automatic logic [9:0] ref_add(input logic [7:0] a, input logic [7:0] b,
                                         input logic cin, input logic sub);
    logic [7:0] bb;
    logic [8:0] f;
    logic       cc;
    logic       ov;
    bb = sub ? ~b : b;
    cc = sub ? 1'b1 : cin;
    f  = {1'b0, a} + {1'b0, bb} + {8'd0, cc};
    ov = (a[7] == bb[7]) && (f[7] != a[7]);
    return {ov, f[8], f[7:0]};
  endfunction

  // Behavioural model: cycles remaining and the pending result.
  logic       m_busy, m_done, m_carry, m_ovf;
  logic [7:0] m_sum;
  logic [9:0] m_pend;
  int         m_left;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  <= 1'b0;
      m_done  <= 1'b0;
      m_sum   <= 8'h00;
      m_carry <= 1'b0;
      m_ovf   <= 1'b0;
      m_left  <= 0;
      m_pend  <= 10'd0;
    end else if (m_busy) begin
      if (m_left == 1) begin
        m_busy  <= 1'b0;
        m_done  <= 1'b1;
        m_sum   <= m_pend[7:0];
        m_carry <= m_pend[8];
        m_ovf   <= m_pend[9];
        m_left  <= 0;
      end else begin
        m_left  <= m_left - 1;
      end
    end else begin
      m_done <= 1'b0;
      if (start) begin
        m_busy <= 1'b1;
        m_left <= 8;
        m_pend <= ref_add(A, B, Cin, SUB);
      end
    end
  end

  // Per-cycle compare of the WIDTH=8 instance against the model.
  always @(negedge clk) begin
    chk("busy", {31'd0, busy}, {31'd0, m_busy});
    chk("done", {31'd0, done}, {31'd0, m_done});
    chk("sum", {24'd0, SUM}, {24'd0, m_sum});
    chk("carry", {31'd0, CARRY}, {31'd0, m_carry});
    chk("overflow", {31'd0, OVERFLOW}, {31'd0, m_ovf});
  end

  task automatic wait_done(output int nbusy);
    int k;
    k = 0;
    nbusy = 0;
    while (done !== 1'b1 && k < 40) begin
      if (busy === 1'b1) nbusy++;
      @(negedge clk);
      k++;
    end
    chk("done_seen", {31'd0, done}, 32'd1);
  endtask

  task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic sub,
                        input logic [7:0] es, input logic ec, input logic eo);
    int nb;
    @(negedge clk);
    A = a; B = b; Cin = cin; SUB = sub; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = 8'($urandom); B = 8'($urandom); Cin = 1'($urandom); SUB = 1'($urandom);
    wait_done(nb);
    chk({name, "_busy_cycles"}, nb, 32'd8);
    chk({name, "_sum"}, {24'd0, SUM}, {24'd0, es});
    chk({name, "_carry"}, {31'd0, CARRY}, {31'd0, ec});
    chk({name, "_ovf"}, {31'd0, OVERFLOW}, {31'd0, eo});
  endtask

  initial begin
    int   nb;
    int   saw_done;
    logic [7:0] corner [4];
    logic [2:0] v;
    corner[0] = 8'h00; corner[1] = 8'h7F; corner[2] = 8'h80; corner[3] = 8'hFF;

    rst_n = 1'b0; start = 1'b0; A = 8'h00; B = 8'h00; Cin = 1'b0; SUB = 1'b0;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0; sub1 = 1'b0;

    // The reference itself, pinned to hand-computed values.
    chk("ref_0f_01", {22'd0, ref_add(8'h0F, 8'h01, 1'b0, 1'b0)}, 32'h010);
    chk("ref_7f_00_c", {22'd0, ref_add(8'h7F, 8'h00, 1'b1, 1'b0)}, 32'h280);
    chk("ref_sub_80_01", {22'd0, ref_add(8'h80, 8'h01, 1'b0, 1'b1)}, 32'h37F);
    chk("ref_sub_05_07", {22'd0, ref_add(8'h05, 8'h07, 1'b1, 1'b1)}, 32'h0FE);

    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_sum", {24'd0, SUM}, 32'd0);
    chk("rst_busy1", {31'd0, busy1}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op("t1", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
    run_op("t2a", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("t2b", 8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op("t3a", 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
    run_op("t3b", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);

    // Start while busy is ignored; start held in DONE re-accepts immediately.
    @(negedge clk);
    A = 8'h12; B = 8'h34; Cin = 1'b0; SUB = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    A = 8'hFF; B = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(nb);
    chk("t4_sum", {24'd0, SUM}, 32'h46);
    A = 8'h20; B = 8'h22; start = 1'b1;
    @(negedge clk);
    chk("t4_reaccept_busy", {31'd0, busy}, 32'd1);
    start = 1'b0;
    wait_done(nb);
    chk("t4_second_sum", {24'd0, SUM}, 32'h42);

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    A = 8'hAA; B = 8'h55; Cin = 1'b0; SUB = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_busy_before", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_done", {31'd0, done}, 32'd0);
    chk("t5_sum", {24'd0, SUM}, 32'd0);
    chk("t5_carry", {31'd0, CARRY}, 32'd0);
    chk("t5_ovf", {31'd0, OVERFLOW}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    saw_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) saw_done++;
    end
    chk("t5_no_done", saw_done, 32'd0);

    // Random traffic, including starts while busy and corner operands.
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      A = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 8'($urandom);
      B = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 8'($urandom);
      Cin = 1'($urandom);
      SUB = 1'($urandom);
      start = ($urandom_range(0, 3) == 0);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);

    // WIDTH=1: registered full adder.
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      @(negedge clk);
      a1 = v[2]; b1 = v[1]; cin1 = v[0]; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      chk("w1_busy", {31'd0, busy1}, 32'd1);
      chk("w1_done_early", {31'd0, done1}, 32'd0);
      @(negedge clk);
      chk("w1_done", {31'd0, done1}, 32'd1);
      chk("w1_sum", {31'd0, sum1}, {31'd0, v[2] ^ v[1] ^ v[0]});
      chk("w1_carry", {31'd0, carry1}, {31'd0, (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0])});
      chk("w1_ovf", {31'd0, ovf1},
          {31'd0, v[0] ^ ((v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]))});
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
